mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU/loader arbiter onto one memory port. Minimum latency is 2 cycles (CS at N+1, DONE at N+2), and MEM_* is held while MEM_READY is low.
// The optional ARB_MISALIGN_TRAP_EN define sends misaligned CPU accesses straight to RESP with MISALIGN=1, and they never reach memory.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_OE,
    input  logic        CPU_WS,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    input  logic [1:0]  CPU_RAM_SEL,
    output logic        CPU_STALL,
    output logic        CPU_DONE,
    input  logic        LD_REQ,
    input  logic        LD_WE,
    input  logic [31:0] LD_ADDR,
    input  logic [31:0] LD_WDATA,
    output logic        LD_DONE,
    output logic [31:0] RDATA,
    output logic        MEM_CS,
    output logic        MEM_WE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, LD_ACC, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        ld_sel_q, ld_sel_d;

    logic        cpu_req;
    logic        grant_ld;
    logic [3:0]  starve_inc;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [1:0]  unused_ld_addr;

    assign unused_ld_addr = LD_ADDR[1:0];

    assign cpu_req    = CPU_OE | CPU_WS;
    assign grant_ld   = LD_REQ & (~cpu_req | (starve_q == LIMIT));
    assign starve_inc = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;

    // Reads always fetch the full word; only stores narrow the byte enables.
    always_comb begin
        cpu_be    = 4'b1111;
        cpu_wdata = CPU_WDATA;
        case (CPU_RAM_SEL)
            2'b01: begin
                cpu_be    = CPU_ADDR[1] ? 4'b1100 : 4'b0011;
                cpu_wdata = {2{CPU_WDATA[15:0]}};
            end
            2'b10: begin
                cpu_be    = 4'b0001 << CPU_ADDR[1:0];
                cpu_wdata = {4{CPU_WDATA[7:0]}};
            end
            default: ;
        endcase
        if (!CPU_WS) begin
            cpu_be = 4'b1111;
        end
    end

`ifdef ARB_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic cpu_misaligned;

    assign cpu_misaligned = ((CPU_RAM_SEL == 2'b00 || CPU_RAM_SEL == 2'b11) && CPU_ADDR[1:0] != 2'b00)
                          || (CPU_RAM_SEL == 2'b01 && CPU_ADDR[0]);
    assign MISALIGN = (state_q == RESP) & mis_q;
`else
    assign MISALIGN = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        ld_sel_d = ld_sel_q;
`ifdef ARB_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_ld) begin
                    state_d  = LD_ACC;
                    starve_d = 4'd0;
                    ld_sel_d = 1'b1;
                    addr_d   = {LD_ADDR[31:2], 2'b00};
                    wdata_d  = LD_WDATA;
                    be_d     = 4'b1111;
                    we_d     = LD_WE;
`ifdef ARB_MISALIGN_TRAP_EN
                    mis_d    = 1'b0;
`endif
                end else if (cpu_req) begin
                    starve_d = LD_REQ ? starve_inc : 4'd0;
                    ld_sel_d = 1'b0;
`ifdef ARB_MISALIGN_TRAP_EN
                    mis_d    = cpu_misaligned;
                    if (cpu_misaligned) begin
                        state_d = RESP;
                    end else begin
                        state_d = CPU_ACC;
                        addr_d  = {CPU_ADDR[31:2], 2'b00};
                        wdata_d = cpu_wdata;
                        be_d    = cpu_be;
                        we_d    = CPU_WS;
                    end
`else
                    state_d  = CPU_ACC;
                    addr_d   = {CPU_ADDR[31:2], 2'b00};
                    wdata_d  = cpu_wdata;
                    be_d     = cpu_be;
                    we_d     = CPU_WS;
`endif
                end
            end
            CPU_ACC, LD_ACC: begin
                if (MEM_READY) begin
                    rdata_d = MEM_RDATA;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            rdata_q  <= 32'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            we_q     <= 1'b0;
            ld_sel_q <= 1'b0;
`ifdef ARB_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            ld_sel_q <= ld_sel_d;
`ifdef ARB_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign MEM_CS    = (state_q == CPU_ACC) || (state_q == LD_ACC);
    assign MEM_WE    = MEM_CS & we_q;
    assign MEM_BE    = be_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign RDATA     = rdata_q;
    assign CPU_DONE  = (state_q == RESP) & ~ld_sel_q;
    assign LD_DONE   = (state_q == RESP) & ld_sel_q;
    assign CPU_STALL = cpu_req & ~CPU_DONE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, CPU lane shaping, loader path, starvation pattern, wait states, reset abort.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_OE, CPU_WS;
    logic [31:0] CPU_ADDR, CPU_WDATA;
    logic [1:0]  CPU_RAM_SEL;
    logic        CPU_STALL, CPU_DONE;
    logic        LD_REQ, LD_WE;
    logic [31:0] LD_ADDR, LD_WDATA;
    logic        LD_DONE;
    logic [31:0] RDATA;
    logic        MEM_CS, MEM_WE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_READY;
    logic        MISALIGN;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_OE(CPU_OE), .CPU_WS(CPU_WS), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_RAM_SEL(CPU_RAM_SEL), .CPU_STALL(CPU_STALL), .CPU_DONE(CPU_DONE),
        .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
        .LD_DONE(LD_DONE), .RDATA(RDATA),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
        .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // One CPU access through zero-wait memory: request at N, CS at N+1, DONE at N+2.
    task automatic cpu_access(input string tag, input logic oe, input logic ws, input logic [1:0] sel,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_addr, input logic [31:0] exp_rd);
        nxt();
        CPU_OE = oe; CPU_WS = ws; CPU_RAM_SEL = sel; CPU_ADDR = addr; CPU_WDATA = wd;
        #1;
        chk({tag, "_stall_n"}, CPU_STALL, 1);
        chk({tag, "_cs_n"}, MEM_CS, 0);
        nxt(); #1;
        chk({tag, "_cs"}, MEM_CS, 1);
        chk({tag, "_we"}, MEM_WE, ws);
        chk({tag, "_be"}, MEM_BE, exp_be);
        chk({tag, "_addr"}, MEM_ADDR, exp_addr);
        if (ws) chk({tag, "_wdata"}, MEM_WDATA, exp_wd);
        chk({tag, "_stall_n1"}, CPU_STALL, 1);
        nxt(); #1;
        chk({tag, "_done"}, CPU_DONE, 1);
        chk({tag, "_lddone"}, LD_DONE, 0);
        chk({tag, "_rdata"}, RDATA, exp_rd);
        chk({tag, "_stall_done"}, CPU_STALL, 0);
        chk({tag, "_misalign"}, MISALIGN, 0);
        CPU_OE = 0; CPU_WS = 0;
    endtask

    initial begin
        logic exp_ld [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int got;
        int extra;

        RST = 1; CPU_OE = 0; CPU_WS = 0; CPU_ADDR = 0; CPU_WDATA = 0; CPU_RAM_SEL = 0;
        LD_REQ = 0; LD_WE = 0; LD_ADDR = 0; LD_WDATA = 0; MEM_RDATA = 0; MEM_READY = 1;

        repeat (3) nxt();
        #1;
        chk("rst_cs", MEM_CS, 0);
        chk("rst_we", MEM_WE, 0);
        chk("rst_cpu_done", CPU_DONE, 0);
        chk("rst_ld_done", LD_DONE, 0);
        chk("rst_misalign", MISALIGN, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_wdata", MEM_WDATA, 0);
        chk("rst_be", MEM_BE, 0);
        chk("rst_stall", CPU_STALL, 0);
        RST = 0;

        MEM_RDATA = 32'hDEADBEEF;
        cpu_access("rd_word", 1, 0, 2'b00, 32'h10, 0, 4'hF, 0, 32'h10, 32'hDEADBEEF);

        // Misaligned word read at 0x6
        nxt();
        MEM_RDATA = 32'h13579BDF; CPU_OE = 1; CPU_RAM_SEL = 2'b00; CPU_ADDR = 32'h6;
        #1;
        chk("mis_cs_n", MEM_CS, 0);
        nxt(); #1;
`ifdef ARB_MISALIGN_TRAP_EN
        chk("mis_cs_n1", MEM_CS, 0);
        chk("mis_done", CPU_DONE, 1);
        chk("mis_flag", MISALIGN, 1);
        chk("mis_rdata", RDATA, 32'hDEADBEEF);
        CPU_OE = 0;
`else
        chk("mis_cs_n1", MEM_CS, 1);
        chk("mis_addr", MEM_ADDR, 32'h4);
        nxt(); #1;
        chk("mis_done", CPU_DONE, 1);
        chk("mis_flag", MISALIGN, 0);
        chk("mis_rdata", RDATA, 32'h13579BDF);
        CPU_OE = 0;
`endif

        MEM_RDATA = 32'h0BADF00D;
        cpu_access("wr_byte3", 0, 1, 2'b10, 32'h23, 32'hAB, 4'b1000, 32'hABABABAB, 32'h20, 32'h0BADF00D);
        cpu_access("wr_half_hi", 0, 1, 2'b01, 32'h102, 32'h1234, 4'b1100, 32'h12341234, 32'h100, 32'h0BADF00D);
        cpu_access("wr_half_lo", 0, 1, 2'b01, 32'h200, 32'hFFFF5678, 4'b0011, 32'h56785678, 32'h200, 32'h0BADF00D);
        cpu_access("wr_sel11", 0, 1, 2'b11, 32'h44, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h44, 32'h0BADF00D);
        MEM_RDATA = 32'h11223344;
        cpu_access("rd_bytesel", 1, 0, 2'b10, 32'h31, 0, 4'b1111, 0, 32'h30, 32'h11223344);
        cpu_access("wr_byte1", 0, 1, 2'b10, 32'h11, 32'h3C, 4'b0010, 32'h3C3C3C3C, 32'h10, 32'h11223344);

        // Loader write, word access regardless of CPU size select
        nxt();
        MEM_RDATA = 32'h2468ACE0; CPU_RAM_SEL = 2'b10;
        LD_REQ = 1; LD_WE = 1; LD_ADDR = 32'h80; LD_WDATA = 32'h55AA55AA;
        #1;
        chk("ld_cs_n", MEM_CS, 0);
        nxt(); #1;
        chk("ld_cs", MEM_CS, 1);
        chk("ld_we", MEM_WE, 1);
        chk("ld_be", MEM_BE, 4'hF);
        chk("ld_addr", MEM_ADDR, 32'h80);
        chk("ld_wdata", MEM_WDATA, 32'h55AA55AA);
        nxt(); #1;
        chk("ld_done", LD_DONE, 1);
        chk("ld_cpu_done", CPU_DONE, 0);
        chk("ld_rdata", RDATA, 32'h2468ACE0);
        LD_REQ = 0;

        // Both requesters held: expect C,C,C,C,L repeating
        nxt();
        CPU_OE = 1; CPU_RAM_SEL = 2'b00; CPU_ADDR = 32'h10; LD_REQ = 1; LD_WE = 0;
        got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            #1;
            if (CPU_DONE || LD_DONE) begin
                chk($sformatf("grant%0d", got), LD_DONE, exp_ld[got]);
                got++;
                if (got == 10) begin
                    CPU_OE = 0; LD_REQ = 0;
                end
            end
            nxt();
        end
        chk("starve_grants", got, 10);

        // Wait states: five cycles of MEM_READY=0
        CPU_WS = 1; CPU_RAM_SEL = 2'b01; CPU_ADDR = 32'h2; CPU_WDATA = 32'hBEEF; MEM_READY = 0;
        nxt();
        for (int i = 0; i < 6; i++) begin
            MEM_READY = (i == 5);
            #1;
            chk($sformatf("wait%0d_cs", i), MEM_CS, 1);
            chk($sformatf("wait%0d_addr", i), MEM_ADDR, 32'h0);
            chk($sformatf("wait%0d_be", i), MEM_BE, 4'b1100);
            chk($sformatf("wait%0d_wdata", i), MEM_WDATA, 32'hBEEFBEEF);
            chk($sformatf("wait%0d_done", i), CPU_DONE, 0);
            nxt();
        end
        #1;
        chk("wait_done", CPU_DONE, 1);
        CPU_WS = 0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            if (CPU_DONE || LD_DONE) extra++;
        end
        chk("wait_one_pulse", extra, 0);

        // Reset while waiting on memory
        nxt();
        MEM_READY = 0; CPU_OE = 1; CPU_RAM_SEL = 2'b00; CPU_ADDR = 32'h40;
        nxt(); #1;
        chk("abort_cs_before", MEM_CS, 1);
        RST = 1;
        nxt(); #1;
        chk("abort_cs", MEM_CS, 0);
        chk("abort_addr", MEM_ADDR, 0);
        chk("abort_rdata", RDATA, 0);
        RST = 0; CPU_OE = 0; MEM_READY = 1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (CPU_DONE || LD_DONE || MEM_CS) extra++;
            nxt();
        end
        chk("abort_no_done", extra, 0);

        // Request that drops before the sampling edge is ignored
        CPU_OE = 1; CPU_ADDR = 32'h99C;
        #1;
        CPU_OE = 0;
        nxt(); #1;
        chk("drop_cs", MEM_CS, 0);
        chk("drop_addr", MEM_ADDR, 0);
        nxt(); #1;
        chk("drop_done", CPU_DONE, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
